button_conditioner: RTL and testbench

//  Input conditioning stage, directly upstream of the shot-clock countdown/display block.

---
 rtl/btn_cond_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 103 ++++++++++
 rtl/button_conditioner.sv | 85 ++++++++
 tb/tb_button_conditioner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the pushbutton / mode-switch conditioning stage.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int CLK_HZ                  = 50_000_000;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 50;
    localparam int DEFAULT_HOLD_CYCLES     = CLK_HZ;

    // One spare bit so the hold counter can saturate at HOLD_CYCLES without wrapping.
    function automatic int counterWidth(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: synchroniser, debounce FSM, and press/release/hold pulse generation.
module debounce_channel
    import btn_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic cin,
    input  logic rst,
    input  logic raw,
    input  logic active_low,
    output logic level,
    output logic press,
    output logic rel,
    output logic hold
);

    localparam int CW = counterWidth(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_DONE = CW'(HOLD_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    btn_state_t             r_state;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          r_holdCnt;
    logic                   r_press;
    logic                   r_rel;
    logic                   r_hold;
    logic                   w_in;
    logic                   w_act;

    // Polarity is corrected before the synchroniser so reset loads the inactive value as 0.
    assign w_in  = raw ^ active_low;
    assign w_act = r_sync[SYNC_STAGES-1];

    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            r_sync    <= '0;
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_holdCnt <= '0;
            r_press   <= 1'b0;
            r_rel     <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], w_in};
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            r_hold  <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (w_act) begin
                        r_state <= PRESS_CHK;
                        r_cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!w_act) begin
                        r_state <= RELEASED;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state   <= PRESSED;
                        r_press   <= 1'b1;
                        r_holdCnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                // Hold keeps counting on the edge that leaves for RELEASE_CHK; it freezes there.
                PRESSED: begin
                    if (!w_act) begin
                        r_state <= RELEASE_CHK;
                        r_cnt   <= '0;
                    end
                    if (r_holdCnt < HOLD_DONE) begin
                        r_holdCnt <= r_holdCnt + CW'(1);
                        if (r_holdCnt == HOLD_LAST) begin
                            r_hold <= 1'b1;
                        end
                    end
                end
                RELEASE_CHK: begin
                    if (w_act) begin
                        r_state <= PRESSED;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= RELEASED;
                        r_rel   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= RELEASED;
            endcase
        end
    end

    assign level = (r_state == PRESSED) || (r_state == RELEASE_CHK);
    assign press = r_press;
    assign rel   = r_rel;
    assign hold  = r_hold;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the KEY pushbuttons and mode switch into clean levels and single-cycle events
// for the shot-clock countdown block, plus a ready flag for latching the initial mode.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic             cin,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold,
    output logic             sw_level,
    output logic             ready
);

    localparam int READY_EDGES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int RW          = $clog2(READY_EDGES) + 1;
    localparam logic [RW-1:0] READY_LAST = RW'(READY_EDGES - 1);
    localparam logic BTN_POL = (BTN_ACTIVE_LOW != 0);

    logic [RW-1:0] r_readyCnt;
    logic          r_ready;
    logic [2:0]    w_swUnused;

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : gen_btn
            debounce_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .HOLD_CYCLES    (HOLD_CYCLES)
            ) u_btn (
                .cin       (cin),
                .rst       (rst),
                .raw       (btn_raw[g]),
                .active_low(BTN_POL),
                .level     (btn_level[g]),
                .press     (btn_press[g]),
                .rel       (btn_release[g]),
                .hold      (btn_hold[g])
            );
        end
    endgenerate

    // The switch reuses the button channel; only its debounced level is consumed.
    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_sw (
        .cin       (cin),
        .rst       (rst),
        .raw       (sw_raw),
        .active_low(1'b0),
        .level     (sw_level),
        .press     (w_swUnused[0]),
        .rel       (w_swUnused[1]),
        .hold      (w_swUnused[2])
    );

    // Rises on the same edge a switch held through reset would be accepted, then sticks.
    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            r_readyCnt <= '0;
            r_ready    <= 1'b0;
        end else if (!r_ready) begin
            if (r_readyCnt == READY_LAST) begin
                r_ready <= 1'b1;
            end else begin
                r_readyCnt <= r_readyCnt + RW'(1);
            end
        end
    end

    assign ready = r_ready;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner with a run-length reference model and directed scenarios.
module tb_button_conditioner;

    localparam int SYNC        = 2;
    localparam int DEB         = 4;
    localparam int HOLD        = 10;
    localparam int READY_EDGES = SYNC + DEB + 1;

    logic       cin = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] btn_raw;
    logic       sw_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_hold;
    logic       sw_level;
    logic       ready;

    button_conditioner #(
        .N_BTN          (2),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .cin        (cin),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .sw_raw     (sw_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold),
        .sw_level   (sw_level),
        .ready      (ready)
    );

    always #5 cin = ~cin;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: channel 0,1 = buttons, 2 = switch. A level flips once the
    // synchronised input has disagreed with it for DEB+1 consecutive edges.
    bit dly[3][SYNC];
    int run[3];
    bit lvl[3];
    int held[3];
    bit fired[3];
    bit ePress[3];
    bit eRel[3];
    bit eHold[3];
    int edges;

    int pressCnt0, relCnt0, holdCnt0, relAny;
    int pressEdge0, relEdge0, holdEdge0, readyEdge, swEdge;
    bit sawBoth;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: observed %0h expected %0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < SYNC; k++) dly[ch][k] = 1'b0;
            run[ch]    = 0;
            lvl[ch]    = 1'b0;
            held[ch]   = 0;
            fired[ch]  = 1'b0;
            ePress[ch] = 1'b0;
            eRel[ch]   = 1'b0;
            eHold[ch]  = 1'b0;
        end
        edges = 0;
    endtask

    task automatic modelEdge();
        for (int ch = 0; ch < 3; ch++) begin
            bit cur;
            bit a;
            bit stablePressed;
            if (ch < 2) cur = ~btn_raw[ch];
            else        cur = sw_raw;
            a = dly[ch][SYNC-1];
            for (int k = SYNC - 1; k > 0; k--) dly[ch][k] = dly[ch][k-1];
            dly[ch][0] = cur;
            ePress[ch] = 1'b0;
            eRel[ch]   = 1'b0;
            eHold[ch]  = 1'b0;
            stablePressed = lvl[ch] && (run[ch] == 0);
            if (a != lvl[ch]) run[ch]++;
            else              run[ch] = 0;
            if (run[ch] == DEB + 1) begin
                lvl[ch] = ~lvl[ch];
                run[ch] = 0;
                if (lvl[ch]) begin
                    ePress[ch] = 1'b1;
                    held[ch]   = 0;
                    fired[ch]  = 1'b0;
                end else begin
                    eRel[ch] = 1'b1;
                end
            end else if (stablePressed && !fired[ch]) begin
                held[ch]++;
                if (held[ch] == HOLD) begin
                    eHold[ch] = 1'b1;
                    fired[ch] = 1'b1;
                end
            end
        end
        edges++;
    endtask

    task automatic clearTrackers();
        pressCnt0  = 0;
        relCnt0    = 0;
        holdCnt0   = 0;
        relAny     = 0;
        pressEdge0 = -1;
        relEdge0   = -1;
        holdEdge0  = -1;
        readyEdge  = -1;
        swEdge     = -1;
        sawBoth    = 1'b0;
    endtask

    task automatic step();
        @(posedge cin);
        if (!rst) modelEdge();
        #1;
        checkOutput("level",   32'(btn_level),   32'({lvl[1], lvl[0]}));
        checkOutput("press",   32'(btn_press),   32'({ePress[1], ePress[0]}));
        checkOutput("release", 32'(btn_release), 32'({eRel[1], eRel[0]}));
        checkOutput("hold",    32'(btn_hold),    32'({eHold[1], eHold[0]}));
        checkOutput("sw",      32'(sw_level),    32'(lvl[2]));
        checkOutput("ready",   32'(ready),       32'(edges >= READY_EDGES));
        if (btn_press[0])   begin pressCnt0++; pressEdge0 = edges; end
        if (btn_release[0]) begin relCnt0++;   relEdge0   = edges; end
        if (btn_hold[0])    begin holdCnt0++;  holdEdge0  = edges; end
        if (|btn_release) relAny++;
        if (btn_press == 2'b11) sawBoth = 1'b1;
        if (ready && readyEdge < 0) readyEdge = edges;
        if (sw_level && swEdge < 0) swEdge = edges;
    endtask

    // Asynchronous assert checked before any clock edge; deassert lands just after an edge.
    task automatic applyReset();
        rst = 1'b1;
        #1;
        modelReset();
        clearTrackers();
        checkOutput("rstLevel",   32'(btn_level),   32'd0);
        checkOutput("rstPress",   32'(btn_press),   32'd0);
        checkOutput("rstRelease", 32'(btn_release), 32'd0);
        checkOutput("rstHold",    32'(btn_hold),    32'd0);
        checkOutput("rstSw",      32'(sw_level),    32'd0);
        checkOutput("rstReady",   32'(ready),       32'd0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] b, input logic s, input int n);
        btn_raw = b;
        sw_raw  = s;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic randomPhase(input int n);
        int segLeft[3];
        bit segVal[3];
        for (int ch = 0; ch < 3; ch++) begin
            segLeft[ch] = 0;
            segVal[ch]  = (ch < 2);
        end
        for (int i = 0; i < n; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (segLeft[ch] == 0) begin
                    segVal[ch]  = 1'($urandom_range(0, 1));
                    segLeft[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                               : int'($urandom_range(6, 30));
                end
                segLeft[ch]--;
            end
            btn_raw = {segVal[1], segVal[0]};
            sw_raw  = segVal[2];
            if (i == n / 2) applyReset();
            step();
        end
    endtask

    int relStart;

    initial begin
        btn_raw = 2'b11;
        sw_raw  = 1'b0;
        #2;

        // Clean press of button 0, held long enough for one hold pulse.
        btn_raw = 2'b10;
        applyReset();
        applyStimulus(2'b10, 1'b0, 30);
        checkOutput("t1PressEdge", 32'(pressEdge0), 32'(READY_EDGES));
        checkOutput("t3HoldDelta", 32'(holdEdge0 - pressEdge0), 32'(HOLD));
        checkOutput("t3HoldOnce",  32'(holdCnt0), 32'd1);

        // Short bounce while pressed, then a clean release.
        clearTrackers();
        applyStimulus(2'b11, 1'b0, 3);
        applyStimulus(2'b10, 1'b0, 10);
        checkOutput("t4NoBounceEvt", 32'(pressCnt0 + relCnt0), 32'd0);
        relStart = edges;
        applyStimulus(2'b11, 1'b0, 12);
        checkOutput("t4RelDelay", 32'(relEdge0 - relStart), 32'(READY_EDGES));
        checkOutput("t4RelOnce",  32'(relCnt0), 32'd1);

        // Glitch shorter than the debounce window.
        clearTrackers();
        applyStimulus(2'b10, 1'b0, 3);
        applyStimulus(2'b11, 1'b0, 10);
        checkOutput("t2NoPress", 32'(pressCnt0), 32'd0);

        // Both buttons together, then reset while pressed.
        clearTrackers();
        applyStimulus(2'b00, 1'b0, 12);
        checkOutput("t5BothPress", 32'(sawBoth), 32'd1);
        btn_raw = 2'b11;
        applyReset();
        applyStimulus(2'b11, 1'b0, 15);
        checkOutput("t5NoRelAfterRst", 32'(relAny), 32'd0);

        // Switch held high through reset.
        sw_raw = 1'b1;
        applyReset();
        applyStimulus(2'b11, 1'b1, 10);
        checkOutput("t6ReadyEdge", 32'(readyEdge), 32'(READY_EDGES));
        checkOutput("t6SwEdge",    32'(swEdge),    32'(READY_EDGES));

        randomPhase(800);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
